mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage responder for the decode-issued memory controls (memen, memwrite, load/store opcode).
//  Turns each access into one req/ack transaction on the data bus and applies byte-lane select/alignment.
//  Sign/zero-extends load data and stalls the pipeline until the bus completes.
//  Sits between the MEM pipeline register and the data SRAM/bus bridge; flags misalignment to the exception logic.
// PARAMETERS
//  TIMEOUT   255  max cycles waiting for bus_ack before bus_err (8-bit counter)
// PORTS
//  clk        in   1   clock, rising edge
//  resetn     in   1   asynchronous active-low reset
//  memen      in   1   MEM-stage access request
//  memwrite   in   1   1=store, 0=load
//  opcode     in   6   MEM-stage opcode; size/sign select
//  addr       in   32  effective byte address
//  wdata      in   32  store data, low-aligned (rt value)
//  flush      in   1   squash current MEM instruction
//  rdata      out  32  aligned, extended load result
//  stall      out  1   hold the pipeline
//  adel       out  1   load address error
//  ades       out  1   store address error
//  bus_err    out  1   one-cycle pulse on timeout
//  bus_req    out  1   bus request
//  bus_we     out  1   bus write enable
//  bus_sel    out  4   byte-lane enables; bit i = byte i (little-endian)
//  bus_addr   out  32  word address; {addr[31:2],2'b00}
//  bus_wdata  out  32  lane-replicated store data
//  bus_ack    in   1   completion; read data valid the same cycle
//  bus_rdata  in   32  read data
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (rdata=0, bus_sel=0, bus_addr=0, stall=0).
//  Decode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
//   Other opcodes with memen=1 are treated as word access.
//  Misalign: half needs addr[0]=0; word needs addr[1:0]=0.
//   If violated: adel (load) or ades (store) is asserted combinationally.
//   No bus request is made; stall=0.
//  Lanes:
//   byte: sel=1<<addr[1:0]; wdata replicated x4.
//   half: sel=addr[1]?1100:0011; wdata replicated x2.
//   word: sel=1111.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE: memen & ~misalign & ~flush -> BUSY. Latch we, sel, addr, wdata, size, sign.
//    bus_req rises the next cycle; stall=1 combinationally in this cycle.
//   BUSY: bus_req=1 and the bus outputs are held stable; stall=1.
//    On bus_ack: register rdata (extended) -> DONE.
//    When the counter reaches TIMEOUT: bus_err pulse, rdata=0 -> DONE.
//   DONE: stall=0; the pipeline advances this cycle; rdata is held valid; -> IDLE.
//  Latency: 1 cycle issue + N cycles to ack + 1 cycle DONE. Zero-wait bus: 3 cycles per access, stall high for 2.
//  Load extension: select byte/half by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
//  Flush during BUSY: the transaction completes (no abort).
//   rdata is not updated and bus_err is suppressed; FSM still passes through DONE.
//   Stores already issued are not cancelled.
//  bus_ack in IDLE/DONE is ignored. A fresh memen in DONE is ignored; it is seen next cycle in IDLE.
//  Reset asserted mid-BUSY: immediate IDLE and bus_req=0. The bus slave must tolerate the dropped request.
//  The timeout counter clears on entering BUSY and saturates.
// STRUCTURE
//  Opcode constants (OP_LB..OP_SW) and FSM state encodings go in the shared defines include, next to the decoder's opcodes.
//  Sub-module mem_align (combinational) contains:
//   size/sign decode and misalign check,
//   bus_sel/bus_wdata generation,
//   load extraction/extension.
//  The top level holds the FSM, latches and timeout counter.
// TESTING
//  1. LW addr=0x1004, bus_ack same cycle as req, bus_rdata=0xDEADBEEF
//     -> bus_sel=1111, bus_addr=0x1004, stall 2 cycles, rdata=0xDEADBEEF.
//  2. LB addr=0x2003, rdata=0x80112233 -> sel=1000, rdata=0xFFFFFF80.
//     LBU, same address -> rdata=0x00000080.
//  3. SH addr=0x3002, wdata=0x0000ABCD
//     -> bus_we=1, sel=1100, bus_wdata=0xABCDABCD; bus_req held for 3 wait cycles until ack.
//  4. LW addr=0x0006 -> adel=1, bus_req never rises, stall=0.
//     SH addr=0x0001 -> ades=1.
//  5. Load with no ack
//     -> bus_err pulse after TIMEOUT cycles in BUSY, rdata=0, stall drops in DONE.
//  6. flush in 2nd BUSY cycle of LW
//     -> bus_req held to ack, rdata unchanged. resetn low in BUSY -> bus_req=0 asynchronously.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared opcode constants, FSM encodings and access-size decode for the
// MEM-stage access unit.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unrecognised opcodes fall back to a word access.
  function automatic size_e decode_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Only the signed sub-word loads sign-extend.
  function automatic logic decode_sign(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-bus handshake between the access unit (master) and the SRAM/bus
// bridge (slave). Read data is valid in the same cycle as ack.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, sel, addr, wdata, input ack, rdata);
  modport slave  (input req, we, sel, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: size/sign decode, alignment check,
// lane enables, store-data replication and load extraction/extension.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output size_e       size,
  output logic        sign_ext,
  output logic        misalign,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  input  size_e       ld_size,
  input  logic        ld_sign,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Issue side: decode size, check alignment, build lanes and store data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statement can leave it unassigned (latch).
    size      = decode_size(opcode);
    sign_ext  = decode_sign(opcode);
    misalign  = 1'b0;
    sel       = 4'b1111;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        sel       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        misalign  = |addr_lo;
      end
    endcase
  end

  // Return side: pick the addressed byte/half and extend it.
  always_comb begin
    case (ld_off)
      2'd0:    byte_v = ld_raw[7:0];
      2'd1:    byte_v = ld_raw[15:8];
      2'd2:    byte_v = ld_raw[23:16];
      default: byte_v = ld_raw[31:24];
    endcase
    half_v = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sign & byte_v[7]}}, byte_v};
      SZ_HALF: ld_data = {{16{ld_sign & half_v[15]}}, half_v};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: turns each load/store into one req/ack bus
// transaction, stalls the pipeline meanwhile, extends load data and flags
// misaligned accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               memen,
  input  logic               memwrite,
  input  logic [5:0]         opcode,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               flush,
  output logic [31:0]        rdata,
  output logic               stall,
  output logic               adel,
  output logic               ades,
  output logic               bus_err,
  mem_access_unit_if.master  bus
);

  state_e      state_q, state_d;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  size_e       size_q;
  logic        sign_q;
  logic [1:0]  off_q;
  logic        kill_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;

  size_e       size_c;
  logic        sign_c;
  logic        misalign_c;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_data;

  logic        issue;
  logic        timeout;
  logic        kill;

  mem_align u_align (
    .opcode    (opcode),
    .addr_lo   (addr[1:0]),
    .wdata     (wdata),
    .size      (size_c),
    .sign_ext  (sign_c),
    .misalign  (misalign_c),
    .sel       (sel_c),
    .wdata_rep (wdata_c),
    .ld_size   (size_q),
    .ld_sign   (sign_q),
    .ld_off    (off_q),
    .ld_raw    (bus.rdata),
    .ld_data   (ld_data)
  );

  // A squashed instruction neither issues nor raises an address error.
  assign issue   = (state_q == ST_IDLE) && memen && !flush && !misalign_c;
  assign timeout = (cnt_q == TIMEOUT);
  // A flush seen in any BUSY cycle, including the completing one, kills the result.
  assign kill    = kill_q || flush;

  // Next-state and pipeline-facing outputs.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    adel    = 1'b0;
    ades    = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memen && !flush) begin
          if (misalign_c) begin
            adel = !memwrite;
            ades = memwrite;
          end else begin
            stall   = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall   = 1'b1;
        bus_err = timeout && !bus.ack && !kill;
        if (bus.ack || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops bus_req immediately, even mid-transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Capture the transaction on issue so the bus sees stable values in BUSY.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
      sign_q  <= 1'b0;
      off_q   <= 2'd0;
    end else if (issue) begin
      we_q    <= memwrite;
      sel_q   <= sel_c;
      addr_q  <= {addr[31:2], 2'b00};
      wdata_q <= wdata_c;
      size_q  <= size_c;
      sign_q  <= sign_c;
      off_q   <= addr[1:0];
    end
  end

  // Wait counter (saturating) and sticky flush flag for the current access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= 8'd0;
      kill_q <= 1'b0;
    end else if (issue) begin
      cnt_q  <= 8'd0;
      kill_q <= 1'b0;
    end else if (state_q == ST_BUSY) begin
      if (!timeout) cnt_q <= cnt_q + 8'd1;
      if (flush)    kill_q <= 1'b1;
    end
  end

  // Load result: extended bus data on ack, zero on timeout, held otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else if ((state_q == ST_BUSY) && !kill) begin
      if (bus.ack) begin
        if (!we_q) rdata_q <= ld_data;
      end else if (timeout) begin
        rdata_q <= '0;
      end
    end
  end

  assign rdata     = rdata_q;
  assign bus.req   = (state_q == ST_BUSY);
  assign bus.we    = we_q;
  assign bus.sel   = sel_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;

endmodule
